// File: rtl/si_dac_rx_pkg.sv
// Shared types and helpers for the serial DAC link receiver and its transmitter bench.
// code_to_volts maps a DAC code to its output voltage for a given reference.
package si_dac_pkg;

    localparam int DATA_W_DEF      = 12;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } rx_state_e;

    function automatic real code_to_volts(input logic [31:0] code,
                                          input int          vref_mv,
                                          input int          data_w = DATA_W_DEF);
        return (real'(vref_mv) / 1000.0) * real'(code) / (2.0 ** data_w);
    endfunction

endpackage

// File: rtl/si_dac_rx_sync_edge.sv
// N-stage synchronizer for one asynchronous link wire, with a history flop
// that turns the synced level into single-cycle rise/fall pulses.
module si_dac_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/si_dac_rx.sv
// Receive side of the 3-wire serial DAC link: oversample, shift MSB first, commit on not_ld rise.
// Define SI_DAC_RX_VOUT_EN to add the simulation-only analog output a_out.
module si_dac_rx
    import si_dac_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int VREF_MV     = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sck,
    input  logic              si,
    input  logic              not_ld,
    output logic [DATA_W-1:0] pdata,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
`ifdef SI_DAC_RX_VOUT_EN
    ,
    output real               a_out
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DATA_W + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("si_dac_rx: SYNC_STAGES must be at least 2");
    end
    if (VREF_MV < 1) begin : g_bad_vref
        $error("si_dac_rx: VREF_MV must be positive");
    end

    logic sck_rise;
    logic ld_rise;
    logic ld_fall;
    logic si_sync;

    si_dac_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .d_i     (sck),
        .level_o (),
        .rise_o  (sck_rise),
        .fall_o  ()
    );

    si_dac_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ld (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .d_i     (not_ld),
        .level_o (),
        .rise_o  (ld_rise),
        .fall_o  (ld_fall)
    );

    si_dac_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_si (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .d_i     (si),
        .level_o (si_sync),
        .rise_o  (),
        .fall_o  ()
    );

    rx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [DATA_W-1:0] pdata_q;
    logic              valid_q;
    logic              err_q;

    // Overrun is remembered by parking the count one past a full word.
    assign bit_cnt_d = (bit_cnt_q == CNT_SAT) ? CNT_SAT : bit_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pdata_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ld_fall) begin
                            bit_cnt_q <= '0;
                            state_q   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // A load edge landing with a clock edge closes the frame first.
                        if (ld_rise) begin
                            state_q <= LOAD;
                        end else if (sck_rise) begin
                            shift_q   <= {shift_q[DATA_W-2:0], si_sync};
                            bit_cnt_q <= bit_cnt_d;
                        end
                    end
                    LOAD: begin
                        if (bit_cnt_q == CNT_FULL) begin
                            pdata_q <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pdata      = pdata_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == SHIFT);

`ifdef SI_DAC_RX_VOUT_EN
    assign a_out = code_to_volts(32'(pdata_q), VREF_MV, DATA_W);
`endif

endmodule

// File: doc/si_dac_rx.md
Name: si_dac_rx

Overview:
- Receive side of the 3-wire serial DAC link (sck, si, not_ld) driven by the sine DAC serializer.
- Oversamples the link in the `clk` domain, deserializes MSB-first words and commits a word on the rising edge of not_ld, like the serial input and load register of a 12-bit serial DAC.
- Used as an on-board loopback checker and as a synthesizable DAC input model in benches.

Parameters:
- DATA_W, 12: word width in bits.
- SYNC_STAGES, 2: synchronizer flops on each link input; minimum 2.
- VREF_MV, 5000: reference voltage in mV, used only by the optional feature.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  receiver enable. When low, the receiver is forced to IDLE and all link edges are ignored.
- sck  in  1  serial clock from the transmitter, asynchronous to clk.
- si  in  1  serial data, MSB first, valid on the sck rising edge.
- not_ld  in  1  frame and load strobe. Low means shifting; the rising edge commits the word.
- pdata  out  DATA_W  last committed word.
- data_valid  out  1  one-cycle pulse when pdata updates.
- frame_err  out  1  one-cycle pulse when a frame closes with a bit count other than DATA_W.
- busy  out  1  high while state is SHIFT.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, shift register 0, bit_cnt 0, synchronizers 0. Outputs: pdata 0, data_valid 0, frame_err 0, busy 0. A reset mid-frame discards the partial word.
- Input path: sck, si and not_ld each pass through SYNC_STAGES flops plus one history flop.
  - sck_rise = synced sck high and history low.
  - ld_fall and ld_rise are detected the same way from not_ld.
  - si is sampled from its synced value in the sck_rise cycle. Transmitter setup must exceed 1 clk period.
- States:
  - IDLE: busy 0. On ld_fall with en high, clear bit_cnt and go to SHIFT.
  - SHIFT: busy 1.
    - On sck_rise: shift_reg <= {shift_reg[DATA_W-2:0], si_sync} and bit_cnt++. bit_cnt saturates at DATA_W+1.
    - On ld_rise: go to LOAD.
    - If en goes low: go to IDLE with no commit and no error.
  - LOAD: single cycle, then IDLE.
    - If bit_cnt == DATA_W: pdata <= shift_reg and data_valid=1.
    - Otherwise frame_err=1 and pdata holds.
- Latency: data_valid and frame_err assert at the clk edge SYNC_STAGES+2 after the first clk edge that samples not_ld high.
- Simultaneous sck_rise and ld_rise in the same cycle: ld_rise wins. That sck edge is not shifted and not counted.
- Overrun (more than DATA_W sck edges): the shift register keeps the last DATA_W bits, bit_cnt = DATA_W+1, and the frame reports frame_err.
- Underrun or empty frame (not_ld low then high with fewer than DATA_W edges, including 0): frame_err, pdata unchanged.
- sck edges in IDLE are ignored. ld_rise in IDLE (e.g. after en drops mid-frame) is ignored.
- data_valid and frame_err are never high together. Each fires at most once per frame.

Optional Feature:
- Macro SI_DAC_RX_VOUT_EN.
- Defined:
  - Adds output port a_out (real, simulation only), equal to VREF_MV/1000.0 * pdata / 2**DATA_W.
  - a_out is 0.0 at reset and updates in the same cycle as pdata.
  - Lets benches compare the analog value directly against the DAC model's A_Sine_data.
- Undefined: port and logic absent; the block is fully synthesizable.

Decomposition:
- Package si_dac_pkg holds:
  - the state enum: IDLE, SHIFT, LOAD;
  - DATA_W_DEF=12 and SYNC_STAGES_DEF=2;
  - the function code_to_volts(code, vref_mv), shared with the transmitter bench.
- One sub-module: si_dac_sync_edge, an N-stage synchronizer with rise/fall pulse outputs, instantiated three times (sck, not_ld, si with edge outputs unused).

Test Plan:
- Nominal frame: not_ld low, 12 sck pulses (8 clk period) sending 0xA5C, not_ld high -> pdata=0xA5C and data_valid pulse 4 clk after the ld edge, frame_err 0. With VOUT_EN, a_out=3.2373 V.
- Back-to-back frames: 0xFFF then 0x001 with 2 clk not_ld-high gap -> two data_valid pulses, pdata 0xFFF then 0x001.
- Underrun: 11 sck pulses then ld rise -> frame_err pulse, pdata keeps the prior 0x001. Overrun with 13 pulses of 1,0×12 -> frame_err, pdata unchanged.
- Collision: 12th sck rise and not_ld rise in the same clk cycle -> bit_cnt=11, frame_err; same stimulus with sck 2 clk earlier -> data_valid.
- Enable: en dropped after 6 bits, frame completed -> no data_valid, no frame_err, busy 0. en restored -> next frame 0x800 commits.
- Reset mid-frame: rst_n low for 1 cycle after 5 bits -> all outputs 0. The remainder of that frame and its ld rise produce nothing; the next full frame 0x123 commits.
